// File: rtl/pc_trace_buffer.sv
// PC change trace FIFO: records each new MEM-stage PC, drops and counts PCs
// that arrive while the buffer is full.
module pc_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   mem_pc,
  input  logic          en,
  input  logic          clr,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v != 16'hFFFF) begin
      sat_inc16 = v + 16'd1;
    end else begin
      sat_inc16 = v;
    end
  endfunction

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic [31:0]   out_pc_q, out_pc_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          cap_s, pop_s, push_s, drop_s;
  logic [AW-1:0] rd_nxt_s;

  // Event decode and next-state computation
  always_comb begin
    cap_s       = en && (mem_pc != last_pc_q);
    pop_s       = out_valid_q && out_ready;
    push_s      = cap_s && ((count_q < DEPTH_C) || pop_s);
    drop_s      = cap_s && !push_s;
    rd_nxt_s    = rd_ptr_q + PTR_ONE;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_pc_d   = last_pc_q;
    out_pc_d    = out_pc_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;

    if (cap_s) begin
      last_pc_d = mem_pc;
    end else begin
      last_pc_d = last_pc_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_nxt_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // Head register tracks the entry that will sit at the read pointer next cycle
    if (pop_s) begin
      if (count_q > (AW+1)'(1)) begin
        out_pc_d = mem_q[rd_nxt_s];
      end else if (push_s) begin
        out_pc_d = mem_pc;
      end else begin
        out_pc_d = out_pc_q;
      end
    end else if (push_s && (count_q == (AW+1)'(0))) begin
      out_pc_d = mem_pc;
    end else begin
      out_pc_d = out_pc_q;
    end

    out_valid_d = (count_d != (AW+1)'(0));

    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end else if (drop_s) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc16(drop_cnt_q);
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_pc_q   <= 32'd0;
      out_pc_q    <= 32'd0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 16'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_pc_q   <= last_pc_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Storage array, intentionally left uninitialised by reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= mem_pc;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
